// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-port register file.
// Optional same-cycle write forwarding is enabled with RF_BYPASS_EN.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  function automatic int rf_aw(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port output select with zero/ready gate.
// With RF_BYPASS_EN defined, forwards same-cycle write data.
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]       ra_i,
  input  logic [XLEN-1:0]     word_i,
  input  logic                ready_i,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   wa_i,
  input  logic [NWR*XLEN-1:0] wd_i,
  output logic [XLEN-1:0]     rd_o
);

`ifdef RF_BYPASS_EN
  always_comb begin
    rd_o = '0;
    if (ready_i && ra_i != '0) begin
      rd_o = word_i;
      // later ports override, matching write priority
      for (int j = 0; j < NWR; j++) begin
        if (we_i[j] && wa_i[j*AW +: AW] == ra_i) begin
          rd_o = wd_i[j*XLEN +: XLEN];
        end
      end
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{we_i, wa_i, wd_i};

  always_comb begin
    rd_o = '0;
    if (ready_i && ra_i != '0) begin
      rd_o = word_i;
    end
  end
`endif

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file with reset-time clear sequencer.
// Build option: RF_BYPASS_EN adds write-to-read forwarding.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int  XLEN = XLEN_DEF,
  parameter int  NREG = NREG_DEF,
  parameter int  NRD  = 2,
  parameter int  NWR  = 2,
  localparam int AW   = rf_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  output logic                ready,
  output logic                wr_conflict
);

  rf_state_e       state_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] rf_q [NREG];
  logic            conflict_q;
  logic            conflict_d;

  always_comb begin
    conflict_d = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (we[j] && we[k] &&
            wa[j*AW +: AW] == wa[k*AW +: AW] &&
            wa[j*AW +: AW] != '0) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    rf_q[0] <= '0;
    if (rst) begin
      state_q    <= RF_CLEAR;
      idx_q      <= AW'(1);
      conflict_q <= 1'b0;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          rf_q[idx_q] <= '0;
          idx_q       <= idx_q + AW'(1);
          conflict_q  <= 1'b0;
          if (idx_q == AW'(NREG - 1)) begin
            state_q <= RF_READY;
          end
        end
        RF_READY: begin
          conflict_q <= conflict_d;
          // ascending loop: highest port wins on address clash
          for (int j = 0; j < NWR; j++) begin
            if (we[j] && wa[j*AW +: AW] != '0) begin
              rf_q[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
            end
          end
        end
        default: state_q <= RF_CLEAR;
      endcase
    end
  end

  assign ready       = (state_q == RF_READY);
  assign wr_conflict = conflict_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_bypass_mux #(
      .XLEN(XLEN),
      .AW  (AW),
      .NWR (NWR)
    ) u_mux (
      .ra_i   (ra[i*AW +: AW]),
      .word_i (rf_q[ra[i*AW +: AW]]),
      .ready_i(ready),
      .we_i   (we),
      .wa_i   (wa),
      .wd_i   (wd),
      .rd_o   (rd[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport (default and 64x16 4R1W).
// Expectations follow RF_BYPASS_EN when it is defined.
module tb_rf_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        ready;
  logic        wr_conflict;

  logic         rst2;
  logic [15:0]  ra2;
  logic [255:0] rd2;
  logic [0:0]   we2;
  logic [3:0]   wa2;
  logic [63:0]  wd2;
  logic         ready2;
  logic         wrc2;

  rf_multiport dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd),
    .we(we), .wa(wa), .wd(wd),
    .ready(ready), .wr_conflict(wr_conflict)
  );

  rf_multiport #(.XLEN(64), .NREG(16), .NRD(4), .NWR(1)) dut2 (
    .clk(clk), .rst(rst2), .ra(ra2), .rd(rd2),
    .we(we2), .wa(wa2), .wd(wd2),
    .ready(ready2), .wr_conflict(wrc2)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];
  bit          mready;
  int          mcnt;
  bit          mconf;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    if (mready && a != 5'd0) begin
      v = mdl[a];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < 2; j++)
        if (we[j] && wa[j*5 +: 5] == a) v = wd[j*32 +: 32];
`endif
    end
    return v;
  endfunction

  // reference update from the inputs present at the coming edge
  task automatic tick();
    if (rst) begin
      mready = 0; mcnt = 0; mconf = 0;
    end else if (!mready) begin
      mcnt++;
      mdl[mcnt] = '0;
      if (mcnt == 31) mready = 1;
      mconf = 0;
    end else begin
      mconf = (we == 2'b11) && (wa[4:0] == wa[9:5]) && (wa[4:0] != 5'd0);
      for (int j = 0; j < 2; j++)
        if (we[j] && wa[j*5 +: 5] != 5'd0) mdl[wa[j*5 +: 5]] = wd[j*32 +: 32];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag);
    check({tag, "_rd0"}, {32'h0, rd[31:0]}, {32'h0, exp_rd(ra[4:0])});
    check({tag, "_rd1"}, {32'h0, rd[63:32]}, {32'h0, exp_rd(ra[9:5])});
  endtask

  task automatic chk_state(input string tag);
    check({tag, "_ready"}, {63'h0, ready}, {63'h0, mready});
    check({tag, "_conf"}, {63'h0, wr_conflict}, {63'h0, mconf});
  endtask

  task automatic read_all(input string tag);
    we = 2'b00;
    for (int a = 0; a < 32; a += 2) begin
      ra = {5'(a + 1), 5'(a)};
      #1;
      chk_rd(tag);
    end
  endtask

  initial begin
    rst = 1; ra = '0; we = '0; wa = '0; wd = '0;
    rst2 = 1; ra2 = '0; we2 = '0; wa2 = '0; wd2 = '0;
    mready = 0; mcnt = 0; mconf = 0;
    tick();
    tick();
    rst = 0; rst2 = 0;
    ra = {5'd9, 5'd5};
    #1;
    chk_rd("rst");
    chk_state("rst");
    check("rst_ready_lit", {63'h0, ready}, 64'h0);

    // clear phase with junk writes that must be ignored
    for (int c = 0; c < 31; c++) begin
      we = 2'($urandom);
      wa = 10'($urandom);
      wd = {$urandom, $urandom};
      ra = 10'($urandom);
      #1;
      chk_rd("clr");
      tick();
      chk_state("clr");
    end
    check("ready_after_31", {63'h0, ready}, 64'h1);
    read_all("clr_zero");

    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
    tick();
    we = 2'b00; ra = {5'd0, 5'd5};
    #1;
    check("x5", {32'h0, rd[31:0]}, 64'hDEADBEEF);
    check("ra0_zero", {32'h0, rd[63:32]}, 64'h0);

    we = 2'b01; wa = 10'd0; wd = {32'h0, 32'h1234};
    tick();
    we = 2'b00; ra = 10'd0;
    #1;
    check("x0", {32'h0, rd[31:0]}, 64'h0);

    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
    tick();
    we = 2'b00; ra = {5'd0, 5'd7};
    #1;
    check("conf_hi", {63'h0, wr_conflict}, 64'h1);
    check("x7", {32'h0, rd[31:0]}, 64'h22);
    tick();
    check("conf_lo", {63'h0, wr_conflict}, 64'h0);

    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h33};
    tick();
    wd = {32'h0, 32'hA5A5A5A5};
    ra = {5'd3, 5'd0};
    #1;
`ifdef RF_BYPASS_EN
    check("byp_same", {32'h0, rd[63:32]}, 64'hA5A5A5A5);
`else
    check("byp_same", {32'h0, rd[63:32]}, 64'h33);
`endif
    tick();
    we = 2'b00;
    #1;
    check("byp_next", {32'h0, rd[63:32]}, 64'hA5A5A5A5);

    for (int n = 0; n < 300; n++) begin
      we = 2'($urandom);
      wa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wd = {$urandom, $urandom};
      ra = {5'($urandom), 5'($urandom_range(0, 7))};
      #1;
      chk_rd("rnd");
      tick();
      chk_state("rnd");
    end

    // reset from READY with nonzero contents, then reset mid-clear
    we = 2'b00; rst = 1;
    tick();
    rst = 0; ra = {5'd7, 5'd5};
    #1;
    check("rr_ready", {63'h0, ready}, 64'h0);
    check("rr_conf", {63'h0, wr_conflict}, 64'h0);
    check("rr_rd", rd, 64'h0);
    for (int c = 0; c < 10; c++) begin
      we = 2'($urandom); wa = 10'($urandom); wd = {$urandom, $urandom};
      tick();
      chk_state("mid");
    end
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 31; c++) begin
      we = 2'($urandom); wa = 10'($urandom); wd = {$urandom, $urandom};
      ra = 10'($urandom);
      #1;
      chk_rd("reclr");
      tick();
      chk_state("reclr");
    end
    check("ready_reclr", {63'h0, ready}, 64'h1);
    read_all("reclr_zero");

    // 64-bit, 16-entry, 4-read, 1-write instance
    rst2 = 1;
    tick();
    rst2 = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      check("p_ready_lo", {63'h0, ready2}, 64'h0);
    end
    tick();
    check("p_ready_hi", {63'h0, ready2}, 64'h1);
    check("p_conf", {63'h0, wrc2}, 64'h0);
    we2 = 1'b1; wa2 = 4'd15; wd2 = 64'hFFFF_0000_1234_5678;
    tick();
    wa2 = 4'd1; wd2 = 64'h1111_1111_0000_0001;
    tick();
    wa2 = 4'd2; wd2 = 64'h2222_2222_0000_0002;
    tick();
    wa2 = 4'd3; wd2 = 64'h3333_3333_0000_0003;
    tick();
    we2 = 1'b0;
    ra2 = {4'd3, 4'd2, 4'd1, 4'd15};
    #1;
    check("p_x15", rd2[63:0], 64'hFFFF_0000_1234_5678);
    check("p_x1", rd2[127:64], 64'h1111_1111_0000_0001);
    check("p_x2", rd2[191:128], 64'h2222_2222_0000_0002);
    check("p_x3", rd2[255:192], 64'h3333_3333_0000_0003);
    ra2 = {4'd0, 4'd15, 4'd4, 4'd3};
    #1;
    check("p_x3b", rd2[63:0], 64'h3333_3333_0000_0003);
    check("p_x4", rd2[127:64], 64'h0);
    check("p_x15b", rd2[191:128], 64'hFFFF_0000_1234_5678);
    check("p_x0", rd2[255:192], 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
